// File: rtl/cp_share_arbiter_if.sv
// Handshake and response bundle between the two engines and the shared cross unit.
// Master = requester side (engines), slave = cp_share_arbiter.
interface cp_share_arbiter_if #(
    parameter int DW = 11,
    parameter int RW = 2 * DW
);
    logic                 flush;
    logic                 req0;
    logic signed [DW-1:0] ax0;
    logic signed [DW-1:0] ay0;
    logic signed [DW-1:0] bx0;
    logic signed [DW-1:0] by0;
    logic                 gnt0;
    logic                 req1;
    logic signed [DW-1:0] ax1;
    logic signed [DW-1:0] ay1;
    logic signed [DW-1:0] bx1;
    logic signed [DW-1:0] by1;
    logic                 gnt1;
    logic                 rsp_valid;
    logic                 rsp_id;
    logic signed [RW-1:0] rsp_cp;
    logic                 rsp_neg;

    modport master (
        output flush,
        output req0, ax0, ay0, bx0, by0,
        output req1, ax1, ay1, bx1, by1,
        input  gnt0, gnt1,
        input  rsp_valid, rsp_id, rsp_cp, rsp_neg
    );

    modport slave (
        input  flush,
        input  req0, ax0, ay0, bx0, by0,
        input  req1, ax1, ay1, bx1, by1,
        output gnt0, gnt1,
        output rsp_valid, rsp_id, rsp_cp, rsp_neg
    );
endinterface

// File: rtl/cp_share_arbiter.sv
// Shares one 2-stage pipelined cross-product unit (cp = ax*by - bx*ay) between two requesters.
// Define CP_SHARE_FIXED_PRI_EN for strict requester-0 priority; default is round-robin.
module cp_share_arbiter #(
    parameter int DW = 11,
    parameter int RW = 2 * DW
) (
    input logic             clk,
    input logic             reset,
    cp_share_arbiter_if.slave bus
);
    logic                 xfer;
    logic                 v1;
    logic                 id1;
    logic signed [DW-1:0] ax_r;
    logic signed [DW-1:0] ay_r;
    logic signed [DW-1:0] bx_r;
    logic signed [DW-1:0] by_r;
    logic signed [RW-1:0] axe;
    logic signed [RW-1:0] aye;
    logic signed [RW-1:0] bxe;
    logic signed [RW-1:0] bye;
    logic                 v2;
    logic                 id2;
    logic signed [RW-1:0] p0;
    logic signed [RW-1:0] p1;
    logic signed [RW-1:0] cp;

`ifdef CP_SHARE_FIXED_PRI_EN
    // Requester 0 always wins; no grants in reset or flush
    always_comb begin
        bus.gnt0 = 1'b0;
        bus.gnt1 = 1'b0;
        if (reset && !bus.flush) begin
            bus.gnt0 = bus.req0;
            bus.gnt1 = bus.req1 & ~bus.req0;
        end
    end
`else
    logic ptr;
    logic gid;

    // Round-robin grant: ptr names the favoured requester on contention
    always_comb begin
        bus.gnt0 = 1'b0;
        bus.gnt1 = 1'b0;
        if (reset && !bus.flush) begin
            bus.gnt0 = bus.req0 & (~bus.req1 | ~ptr);
            bus.gnt1 = bus.req1 & (~bus.req0 | ptr);
        end
    end

    assign gid = bus.gnt1;

    // Only contended transfers move the pointer, to the loser
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (bus.flush) begin
            ptr <= 1'b0;
        end else if (bus.req0 && bus.req1 && xfer) begin
            ptr <= ~gid;
        end
    end
`endif

    assign xfer = bus.gnt0 | bus.gnt1;

    assign axe = {{(RW-DW){ax_r[DW-1]}}, ax_r};
    assign aye = {{(RW-DW){ay_r[DW-1]}}, ay_r};
    assign bxe = {{(RW-DW){bx_r[DW-1]}}, bx_r};
    assign bye = {{(RW-DW){by_r[DW-1]}}, by_r};
    assign cp  = p0 - p1;

    // Operand capture, product stage and result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1            <= 1'b0;
            id1           <= 1'b0;
            ax_r          <= '0;
            ay_r          <= '0;
            bx_r          <= '0;
            by_r          <= '0;
            v2            <= 1'b0;
            id2           <= 1'b0;
            p0            <= '0;
            p1            <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_cp    <= '0;
            bus.rsp_neg   <= 1'b0;
        end else if (bus.flush) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            bus.rsp_valid <= 1'b0;
        end else begin
            v1 <= xfer;
            if (xfer) begin
                id1  <= bus.gnt1;
                ax_r <= bus.gnt1 ? bus.ax1 : bus.ax0;
                ay_r <= bus.gnt1 ? bus.ay1 : bus.ay0;
                bx_r <= bus.gnt1 ? bus.bx1 : bus.bx0;
                by_r <= bus.gnt1 ? bus.by1 : bus.by0;
            end
            v2 <= v1;
            if (v1) begin
                id2 <= id1;
                p0  <= axe * bye;
                p1  <= bxe * aye;
            end
            bus.rsp_valid <= v2;
            if (v2) begin
                bus.rsp_id  <= id2;
                bus.rsp_cp  <= cp;
                bus.rsp_neg <= cp[RW-1];
            end
        end
    end
endmodule

// File: tb/tb_cp_share_arbiter.sv
// Self-checking bench for cp_share_arbiter: directed cases then random traffic
// against a queue-based reference model of grants and tagged results.
module tb_cp_share_arbiter;
    localparam int DW = 11;
    localparam int RW = 22;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total = 0;

    int o0[4];
    int o1[4];
    bit r0;
    bit r1;
    bit fl;
    bit g0;
    bit g1;
    int fav = 0;
    bit known = 1'b1;
    int last_id = 0;
    int last_cp = 0;
    int cyc = 0;
    int q_due[$];
    int q_id[$];
    int q_cp[$];
    logic [3:0] seq;

    cp_share_arbiter_if #(.DW(DW), .RW(RW)) bus ();

    cp_share_arbiter #(.DW(DW), .RW(RW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [RW-1:0] obs,
                         input logic [RW-1:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int xp(input int v[4]);
        return v[0] * v[3] - v[2] * v[1];
    endfunction

    task automatic rnd(output int v[4]);
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 7) == 0)
                v[k] = ($urandom_range(0, 1) == 1) ? 1023 : -1023;
            else
                v[k] = int'($urandom_range(0, 2046)) - 1023;
        end
    endtask

    task automatic apply();
        bus.req0  = r0;
        bus.req1  = r1;
        bus.flush = fl;
        bus.ax0 = DW'(o0[0]);
        bus.ay0 = DW'(o0[1]);
        bus.bx0 = DW'(o0[2]);
        bus.by0 = DW'(o0[3]);
        bus.ax1 = DW'(o1[0]);
        bus.ay1 = DW'(o1[1]);
        bus.bx1 = DW'(o1[2]);
        bus.by1 = DW'(o1[3]);
    endtask

    task automatic model_reset();
        q_due.delete();
        q_id.delete();
        q_cp.delete();
        fav = 0;
        known = 1'b1;
        last_id = 0;
        last_cp = 0;
    endtask

    // One clock: predict grants, then compare the response side after the edge.
    task automatic tick();
        bit e0;
        bit e1;
        apply();
        e0 = 1'b0;
        e1 = 1'b0;
        if (!fl) begin
`ifdef CP_SHARE_FIXED_PRI_EN
            e0 = r0;
            e1 = r1 && !r0;
`else
            if (r0 && r1) begin
                e0 = (fav == 0);
                e1 = !e0;
                fav = e0 ? 1 : 0;
            end else begin
                e0 = r0;
                e1 = r1;
            end
`endif
        end
        g0 = e0;
        g1 = e1;
        #1;
        check("gnt0", bus.gnt0, e0);
        check("gnt1", bus.gnt1, e1);
        @(posedge clk);
        cyc++;
        if (fl) begin
            q_due.delete();
            q_id.delete();
            q_cp.delete();
            fav = 0;
            known = 1'b0;
        end else if (e0 || e1) begin
            q_due.push_back(cyc + 2);
            q_id.push_back(e1 ? 1 : 0);
            q_cp.push_back(e1 ? xp(o1) : xp(o0));
        end
        #1;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            void'(q_due.pop_front());
            last_id = q_id.pop_front();
            last_cp = q_cp.pop_front();
            known = 1'b1;
            check("rsp_valid", bus.rsp_valid, 1);
        end else begin
            check("rsp_valid", bus.rsp_valid, 0);
        end
        if (known) begin
            check("rsp_id", bus.rsp_id, last_id[0]);
            check("rsp_cp", bus.rsp_cp, RW'(last_cp));
            check("rsp_neg", bus.rsp_neg, last_cp < 0);
        end
        @(negedge clk);
    endtask

    initial begin
        o0 = '{0, 0, 0, 0};
        o1 = '{0, 0, 0, 0};
        r0 = 1'b1;
        r1 = 1'b1;
        fl = 1'b0;
        apply();

        // Reset: outputs cleared, no grants while reset low
        #2 reset = 1'b0;
        #1;
        check("rst_valid", bus.rsp_valid, 0);
        check("rst_id", bus.rsp_id, 0);
        check("rst_cp", bus.rsp_cp, 0);
        check("rst_neg", bus.rsp_neg, 0);
        check("rst_gnt0", bus.gnt0, 0);
        check("rst_gnt1", bus.gnt1, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        r0 = 1'b0;
        r1 = 1'b0;
        model_reset();
        tick();

        // Single op from requester 0
        o0 = '{3, 0, 0, 4};
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        tick();
        tick();
        check("t1_valid", bus.rsp_valid, 1);
        check("t1_cp", bus.rsp_cp, RW'(12));
        check("t1_id", bus.rsp_id, 0);

        // Signed extremes, both orientations
        o0 = '{-1023, 1023, 1023, 1023};
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        tick();
        tick();
        check("t2_cp", bus.rsp_cp, RW'(-2093058));
        check("t2_neg", bus.rsp_neg, 1);
        o0 = '{1023, 1023, -1023, 1023};
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        tick();
        tick();
        check("t2s_cp", bus.rsp_cp, RW'(2093058));
        check("t2s_neg", bus.rsp_neg, 0);

        // Contention for 4 cycles starting from ptr=0
        o0 = '{5, -7, 9, 11};
        o1 = '{-13, 2, 6, -4};
        r0 = 1'b1;
        r1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply();
            #1;
            seq[i] = bus.gnt1;
            tick();
            if (g0) o0 = '{o0[0] + 17, o0[1] - 3, o0[2] + 1, o0[3] * 2};
            if (g1) o1 = '{o1[0] - 5, o1[1] + 8, o1[2] - 9, o1[3] + 100};
        end
        r0 = 1'b0;
        r1 = 1'b0;
        tick();
        tick();
`ifdef CP_SHARE_FIXED_PRI_EN
        check("t3_seq", seq, 4'b0000);
`else
        check("t3_seq", seq, 4'b1010);
`endif

        // Flush drops in-flight work and resets the pointer
        o0 = '{100, -50, 25, 75};
        o1 = '{-8, 8, 8, 8};
        r0 = 1'b1;
        r1 = 1'b1;
        tick();
        if (g0) o0 = '{-1, 1, 1, 1};
        if (g1) o1 = '{-2, 2, 2, 2};
        fl = 1'b1;
        tick();
        fl = 1'b0;
        apply();
        #1;
        check("t4_ptr", bus.gnt0, 1);
        tick();
        r0 = 1'b0;
        tick();
        tick();
        tick();
        r1 = 1'b1;
        o1 = '{4, 3, 2, 1};
        fl = 1'b1;
        tick();
        fl = 1'b0;
        apply();
        #1;
        check("t4_gnt1", bus.gnt1, 1);
        tick();
        r1 = 1'b0;
        tick();
        tick();

        // Async reset with two ops in flight
        o0 = '{7, 1, 2, 9};
        o1 = '{-3, 5, 4, 6};
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        r1 = 1'b1;
        tick();
        r0 = 1'b1;
        r1 = 1'b0;
        apply();
        #2 reset = 1'b0;
        #1;
        check("t5_valid", bus.rsp_valid, 0);
        check("t5_cp", bus.rsp_cp, 0);
        check("t5_id", bus.rsp_id, 0);
        check("t5_neg", bus.rsp_neg, 0);
        check("t5_gnt0", bus.gnt0, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        r0 = 1'b0;
        tick();
        tick();
        tick();
        o1 = '{-9, 2, 3, 4};
        r1 = 1'b1;
        tick();
        r1 = 1'b0;
        tick();
        tick();
        check("t5_lat", bus.rsp_valid, 1);
        check("t5_cp2", bus.rsp_cp, RW'(-42));

        // Collinear vectors give zero
        o0 = '{2, 4, 1, 2};
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        tick();
        tick();
        check("t6_cp", bus.rsp_cp, 0);
        check("t6_neg", bus.rsp_neg, 0);

        // Random traffic with requesters honouring the hold rule
        r0 = 1'b0;
        r1 = 1'b0;
        g0 = 1'b0;
        g1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!r0 || g0) begin
                r0 = ($urandom_range(0, 3) != 0);
                rnd(o0);
            end
            if (!r1 || g1) begin
                r1 = ($urandom_range(0, 3) != 0);
                rnd(o1);
            end
            fl = ($urandom_range(0, 24) == 0);
            tick();
        end
        r0 = 1'b0;
        r1 = 1'b0;
        fl = 1'b0;
        tick();
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
